mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ID, default 0: instance number printed in simulation trace messages.
REQ-002 SHALL have parameter ADDR_B, default 10: log2 of the storage depth in 32-bit words.
REQ-003 SHALL have parameter LAT, default 4 (legal range >=1): cycles from request acceptance to the done pulse.
REQ-004 clk  in  1  sole clock; every state change happens on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 re  in  1  read request, sampled each rising edge.
REQ-007 we  in  1  write request, sampled each rising edge.
REQ-008 raddr  in  32  read byte address.
REQ-009 waddr  in  32  write byte address.
REQ-010 rlen  in  2  read length code.
REQ-011 wlen  in  2  write length code.
REQ-012 din  in  32  write data, right-aligned.
REQ-013 dout  out  32  read data, zero-extended.
REQ-014 busy  out  1  high while a request is in flight or a read is pending.
REQ-015 done  out  1  one-cycle pulse marking completion of each request.
REQ-016 err  out  1  misalignment flag, valid only in the done cycle.

Function
REQ-017 Length codes SHALL be: 0 = byte, 1 = halfword, 2 = word, 3 = word.
REQ-018 Storage SHALL be 2^ADDR_B words; word index = addr[ADDR_B+1:2], byte lane = addr[1:0]; address bits above ADDR_B+1 are ignored (aliasing).
REQ-019 FSM states SHALL be IDLE, WR_WAIT, RD_WAIT; the wait counter is loaded with LAT-1 on entry to a wait state and decrements each cycle.
REQ-020 IDLE with we=1 at an edge: SHALL latch waddr, wlen, din, assert busy and enter WR_WAIT.
REQ-021 IDLE with only re=1: SHALL latch raddr and rlen, assert busy and enter RD_WAIT.
REQ-022 IDLE with re=1 and we=1 in the same cycle: SHALL perform the write first; the read is latched as pending, its RD_WAIT starts the cycle after the write's done, and the read returns the newly written data.
REQ-023 re or we asserted while busy=1 SHALL be ignored; the block accepts no queueing beyond the REQ-022 pending read.
REQ-024 Wait state with counter = 0: SHALL pulse done for one cycle; a write commits to storage on that edge; read data appears on dout in the done cycle.
REQ-025 dout SHALL hold its value until the next read's done.
REQ-026 After a done, SHALL return to IDLE, or go to RD_WAIT if a read is pending.
REQ-027 busy SHALL deassert in the cycle after done when nothing is pending, so a new request is accepted at the earliest LAT+1 cycles after the previous one.
REQ-028 Byte write SHALL update only lane addr[1:0] from din[7:0].
REQ-029 Halfword write SHALL update lanes {addr[1],0} and {addr[1],1} from din[15:0].
REQ-030 Byte read SHALL return the selected lane zero-extended to 32 bits; halfword read the selected half zero-extended; word read all 32 bits.
REQ-031 Halfword access with addr[0]=1, or word access with addr[1:0]!=0: SHALL raise err with done, write nothing, and drive dout=0 for a read.
REQ-032 Simulation SHALL $display ID, operation, address and data at each done.

Reset
REQ-033 On rst=1 at an edge: state <= IDLE, counter <= 0, pending read cleared, busy <= 0, done <= 0, err <= 0, dout <= 0.
REQ-034 Reset SHALL NOT clear storage; a write in flight when reset is asserted SHALL NOT commit.
REQ-035 rst SHALL take priority over re/we in the same cycle.

Structure
REQ-036 Data/address/length widths and the length-code constants SHALL live in shared def.v; storage depth and latency remain local parameters.
REQ-037 Byte-lane merge/extract and the alignment check SHALL be one combinational sub-module, mem_lane.

Verification
REQ-038 LAT=4: word write 0xDEADBEEF @0x10 at cycle 0 -> done at cycle 4; word read @0x10 -> dout=0xDEADBEEF, err=0.
REQ-039 Byte write 0xAA @0x13 over 0x11223344 -> word read @0x10 = 0xAA223344; byte read @0x12 = 0x00000022; half read @0x12 = 0x0000AA22.
REQ-040 Same-cycle re/we to 0x20 with din=0x55 -> two done pulses LAT cycles apart; the read returns 0x55.
REQ-041 Half write @0x21 -> err=1 with done and storage unchanged; word read @0x22 -> err=1, dout=0.
REQ-042 re pulsed while busy -> no extra done; rst asserted mid-WR_WAIT -> busy=0 the next cycle and the target word unchanged.
REQ-043 ADDR_B=10: write @0x1000 then read @0x0 -> aliased data returned.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
// Shared definitions for the memory responder: bus widths, access length codes,
// FSM state encoding and the alignment rule used by the lane logic.
// -----------------------------------------------------------------------------
package mem_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 2;

  // Access length codes; code 3 is a second spelling of a word access.
  localparam logic [LEN_W-1:0] LEN_BYTE     = 2'd0;
  localparam logic [LEN_W-1:0] LEN_HALF     = 2'd1;
  localparam logic [LEN_W-1:0] LEN_WORD     = 2'd2;
  localparam logic [LEN_W-1:0] LEN_WORD_ALT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

  // Halfwords must sit on an even byte, words on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] lane,
                                         input logic [LEN_W-1:0] len);
    logic bad;
    case (len)
      LEN_BYTE: bad = 1'b0;
      LEN_HALF: bad = lane[0];
      default:  bad = (lane != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between a requester (master) and the memory
// responder (slave).
//   re/we        : read / write request strobes
//   raddr/waddr  : byte addresses
//   rlen/wlen    : length codes (byte, halfword, word)
//   din          : right-aligned write data
//   dout         : zero-extended read data, held until the next read completes
//   busy/done/err: in-flight flag, completion pulse, misalignment flag
// -----------------------------------------------------------------------------
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              re;
  logic              we;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] waddr;
  logic [LEN_W-1:0]  rlen;
  logic [LEN_W-1:0]  wlen;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output re, we, raddr, waddr, rlen, wlen, din,
    input  dout, busy, done, err
  );

  modport slave (
    input  re, we, raddr, waddr, rlen, wlen, din,
    output dout, busy, done, err
  );

endinterface

// File: rtl/mem_responder_lane.sv
// -----------------------------------------------------------------------------
// mem_lane
// Purely combinational byte-lane logic for the memory responder.
//   i_wlane/i_wlen/i_wdata/i_old : write lane, length, data and current word
//   o_merged/o_werr              : word after the write merge, misalignment flag
//   i_rlane/i_rlen/i_rword       : read lane, length and stored word
//   o_rdata/o_rerr               : zero-extended read data (0 when misaligned)
// -----------------------------------------------------------------------------
module mem_lane
  import mem_responder_pkg::*;
(
  input  logic [1:0]        i_wlane,
  input  logic [LEN_W-1:0]  i_wlen,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_old,
  output logic [DATA_W-1:0] o_merged,
  output logic              o_werr,
  input  logic [1:0]        i_rlane,
  input  logic [LEN_W-1:0]  i_rlen,
  input  logic [DATA_W-1:0] i_rword,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rerr
);

  // Write merge: overlay the addressed lanes of the current word.
  always_comb begin
    o_merged = i_old;
    o_werr   = is_misaligned(i_wlane, i_wlen);
    case (i_wlen)
      LEN_BYTE:               o_merged[{i_wlane, 3'b000} +: 8]        = i_wdata[7:0];
      LEN_HALF:               o_merged[{i_wlane[1], 4'b0000} +: 16]   = i_wdata[15:0];
      LEN_WORD, LEN_WORD_ALT: o_merged                                = i_wdata;
      default:                o_merged                                = i_wdata;
    endcase
  end

  // Read extract: select lanes and zero-extend; misaligned reads return 0.
  always_comb begin
    o_rdata = 32'h0000_0000;
    o_rerr  = is_misaligned(i_rlane, i_rlen);
    if (o_rerr) begin
      o_rdata = 32'h0000_0000;
    end else begin
      case (i_rlen)
        LEN_BYTE:               o_rdata = {24'h00_0000, i_rword[{i_rlane, 3'b000} +: 8]};
        LEN_HALF:               o_rdata = {16'h0000, i_rword[{i_rlane[1], 4'b0000} +: 16]};
        LEN_WORD, LEN_WORD_ALT: o_rdata = i_rword;
        default:                o_rdata = i_rword;
      endcase
    end
  end

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Fixed-latency word-organised memory model with byte/halfword/word access.
// A request is accepted from IDLE, waits LAT cycles (done in the last one) and
// then returns to IDLE. A read arriving together with a write is held pending
// and runs after the write, seeing the written data.
//   clk  : sole clock
//   rst  : synchronous active-high reset (storage is not cleared)
//   bus  : slave side of mem_responder_if
// Outputs are registered; done/err/dout are computed from the next-cycle view
// of the FSM so that they are valid in the cycle the wait counter reads zero.
// -----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ID     = 0,
  parameter int ADDR_B = 10,
  parameter int LAT    = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int AW    = ADDR_B + 2;
  localparam int DEPTH = 1 << ADDR_B;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (LAT < 1) begin : g_lat_chk
    $error("mem_responder: LAT must be at least 1");
  end
  if (ID < 0) begin : g_id_chk
    $error("mem_responder: ID must be non-negative");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_pend, w_pend_nxt;
  logic              r_done, r_err, r_werr;
  logic [AW-1:0]     r_waddr, r_raddr, w_waddr_nxt, w_raddr_nxt;
  logic [LEN_W-1:0]  r_wlen, r_rlen, w_wlen_nxt, w_rlen_nxt;
  logic [DATA_W-1:0] r_din, w_din_nxt, r_wmerge, r_dout;
  logic [DATA_W-1:0] w_wold, w_rword, w_merged, w_rdata;
  logic              w_ld_w, w_ld_r, w_commit, w_werr, w_rerr;
  logic              w_done_nxt, w_rd_done_nxt, w_wr_done_nxt;
  logic              w_unused_addr;

  // Upper address bits alias onto the storage and are intentionally dropped.
  assign w_unused_addr = ^{bus.waddr[ADDR_W-1:AW], bus.raddr[ADDR_W-1:AW]};

  // FSM next state, wait counter and request-latch enables.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_pend_nxt  = r_pend;
    w_ld_w      = 1'b0;
    w_ld_r      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.we) begin
          // A simultaneous read is captured now and run after the write.
          w_ld_w      = 1'b1;
          w_ld_r      = bus.re;
          w_pend_nxt  = bus.re;
          w_state_nxt = ST_WR_WAIT;
          w_cnt_nxt   = CNT_LOAD;
          w_busy_nxt  = 1'b1;
        end else if (bus.re) begin
          w_ld_r      = 1'b1;
          w_state_nxt = ST_RD_WAIT;
          w_cnt_nxt   = CNT_LOAD;
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      ST_WR_WAIT: begin
        if (r_cnt == CNT_ZERO) begin
          if (r_pend) begin
            w_state_nxt = ST_RD_WAIT;
            w_cnt_nxt   = CNT_LOAD;
            w_pend_nxt  = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      ST_RD_WAIT: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_ZERO;
        w_busy_nxt  = 1'b0;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  // Request fields as they will be held next cycle.
  assign w_waddr_nxt = w_ld_w ? bus.waddr[AW-1:0] : r_waddr;
  assign w_wlen_nxt  = w_ld_w ? bus.wlen          : r_wlen;
  assign w_din_nxt   = w_ld_w ? bus.din           : r_din;
  assign w_raddr_nxt = w_ld_r ? bus.raddr[AW-1:0] : r_raddr;
  assign w_rlen_nxt  = w_ld_r ? bus.rlen          : r_rlen;

  // Completion seen from the next cycle: wait state with counter at zero.
  assign w_done_nxt    = (w_state_nxt != ST_IDLE) && (w_cnt_nxt == CNT_ZERO);
  assign w_rd_done_nxt = (w_state_nxt == ST_RD_WAIT) && (w_cnt_nxt == CNT_ZERO);
  assign w_wr_done_nxt = (w_state_nxt == ST_WR_WAIT) && (w_cnt_nxt == CNT_ZERO);

  // The current done cycle of an aligned write commits on this edge.
  assign w_commit = (r_state == ST_WR_WAIT) && (r_cnt == CNT_ZERO) && !r_werr;

  // A read completing right after a write commit must see the committed word.
  assign w_wold  = r_mem[w_waddr_nxt[AW-1:2]];
  assign w_rword = (w_commit && (w_raddr_nxt[AW-1:2] == r_waddr[AW-1:2]))
                   ? r_wmerge : r_mem[w_raddr_nxt[AW-1:2]];

  mem_lane u_lane (
    .i_wlane  (w_waddr_nxt[1:0]),
    .i_wlen   (w_wlen_nxt),
    .i_wdata  (w_din_nxt),
    .i_old    (w_wold),
    .o_merged (w_merged),
    .o_werr   (w_werr),
    .i_rlane  (w_raddr_nxt[1:0]),
    .i_rlen   (w_rlen_nxt),
    .i_rword  (w_rword),
    .o_rdata  (w_rdata),
    .o_rerr   (w_rerr)
  );

  // Control state, request latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= CNT_ZERO;
      r_busy   <= 1'b0;
      r_pend   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_werr   <= 1'b0;
      r_dout   <= 32'h0000_0000;
      r_waddr  <= '0;
      r_raddr  <= '0;
      r_wlen   <= 2'd0;
      r_rlen   <= 2'd0;
      r_din    <= 32'h0000_0000;
      r_wmerge <= 32'h0000_0000;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_pend   <= w_pend_nxt;
      r_done   <= w_done_nxt;
      r_err    <= (w_rd_done_nxt && w_rerr) || (w_wr_done_nxt && w_werr);
      r_werr   <= w_werr;
      r_waddr  <= w_waddr_nxt;
      r_raddr  <= w_raddr_nxt;
      r_wlen   <= w_wlen_nxt;
      r_rlen   <= w_rlen_nxt;
      r_din    <= w_din_nxt;
      r_wmerge <= w_merged;
      if (w_rd_done_nxt) begin
        r_dout <= w_rdata;
      end else begin
        r_dout <= r_dout;
      end
    end
  end

  // Storage has no reset; a commit coinciding with rst is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_commit) begin
      r_mem[r_waddr[AW-1:2]] <= r_wmerge;
    end
  end

  assign bus.dout = r_dout;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed stimulus with a scoreboard queue: each issued request pushes its
// expected completion (cycle, error flag, read data); a monitor on the falling
// edge pops and compares whenever done is high.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int ID     = 0;
  localparam int ADDR_B = 10;
  localparam int LAT    = 4;

  typedef struct {
    bit          is_rd;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q[$];

  mem_responder_if bus ();

  mem_responder #(.ID(ID), .ADDR_B(ADDR_B), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done at cycle %0d, required no done", cyc);
      end else begin
        e = q.pop_front();
        $display("[mem_responder %0d] %s addr=0x%08h data=0x%08h err=%0b",
                 ID, e.is_rd ? "read " : "write", e.addr,
                 e.is_rd ? bus.dout : e.data, bus.err);
        chk($sformatf("done_cycle@%08h", e.addr), 32'(cyc), 32'(e.cyc));
        chk($sformatf("err@%08h", e.addr), {31'd0, bus.err}, {31'd0, e.err});
        if (e.is_rd) chk($sformatf("rdata@%08h", e.addr), bus.dout, e.data);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      $display("FAIL busy_timeout: busy=%b after 100 cycles, required 0", bus.busy);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d,
                    input bit e);
    wait_idle();
    bus.we = 1'b1; bus.waddr = a; bus.wlen = l; bus.din = d;
    q.push_back('{1'b0, cyc + LAT, a, d, e});
    @(posedge clk); #1;
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] l, input logic [31:0] d,
                    input bit e);
    wait_idle();
    bus.re = 1'b1; bus.raddr = a; bus.rlen = l;
    q.push_back('{1'b1, cyc + LAT, a, d, e});
    @(posedge clk); #1;
    bus.re = 1'b0;
  endtask

  initial begin
    int n;
    bus.re = 1'b0; bus.we = 1'b0; bus.raddr = 32'h0; bus.waddr = 32'h0;
    bus.rlen = 2'd0; bus.wlen = 2'd0; bus.din = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_err",  {31'd0, bus.err},  32'd0);
    chk("rst_dout", bus.dout, 32'h0000_0000);

    // Basic word write/read with done latency
    wr(32'h10, 2'd2, 32'hDEAD_BEEF, 1'b0);
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    rd(32'h10, 2'd2, 32'hDEAD_BEEF, 1'b0);

    // Byte merge and lane extraction
    wr(32'h10, 2'd2, 32'h1122_3344, 1'b0);
    wr(32'h13, 2'd0, 32'hFFFF_FFAA, 1'b0);
    rd(32'h10, 2'd2, 32'hAA22_3344, 1'b0);
    rd(32'h12, 2'd0, 32'h0000_0022, 1'b0);
    rd(32'h12, 2'd1, 32'h0000_AA22, 1'b0);
    rd(32'h13, 2'd0, 32'h0000_00AA, 1'b0);
    rd(32'h10, 2'd1, 32'h0000_3344, 1'b0);
    rd(32'h10, 2'd3, 32'hAA22_3344, 1'b0);

    // Same-cycle write and read: read follows and sees the new data
    wait_idle();
    bus.we = 1'b1; bus.waddr = 32'h20; bus.wlen = 2'd2; bus.din = 32'h0000_0055;
    bus.re = 1'b1; bus.raddr = 32'h20; bus.rlen = 2'd2;
    q.push_back('{1'b0, cyc + LAT, 32'h20, 32'h55, 1'b0});
    q.push_back('{1'b1, cyc + 2 * LAT, 32'h20, 32'h55, 1'b0});
    @(posedge clk); #1;
    bus.we = 1'b0; bus.re = 1'b0;

    // Misaligned accesses
    wr(32'h21, 2'd1, 32'h0000_BEEF, 1'b1);
    rd(32'h20, 2'd2, 32'h0000_0055, 1'b0);
    rd(32'h22, 2'd2, 32'h0000_0000, 1'b1);
    rd(32'h21, 2'd0, 32'h0000_0000, 1'b0);
    wr(32'h22, 2'd1, 32'h1234_5678, 1'b0);
    rd(32'h20, 2'd2, 32'h5678_0055, 1'b0);
    wr(32'h50, 2'd3, 32'h8765_4321, 1'b0);
    rd(32'h50, 2'd2, 32'h8765_4321, 1'b0);

    // Requests while busy are dropped
    wr(32'h30, 2'd2, 32'hCAFE_F00D, 1'b0);
    bus.re = 1'b1; bus.raddr = 32'h10; bus.rlen = 2'd2;
    repeat (3) begin @(posedge clk); #1; end
    bus.re = 1'b0;
    rd(32'h30, 2'd2, 32'hCAFE_F00D, 1'b0);

    // Reset during WR_WAIT: no commit, no done, rst beats a read request
    wr(32'h40, 2'd2, 32'h0102_0304, 1'b0);
    wait_idle();
    bus.we = 1'b1; bus.waddr = 32'h40; bus.wlen = 2'd2; bus.din = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    bus.we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; bus.re = 1'b1; bus.raddr = 32'h40; bus.rlen = 2'd2;
    @(posedge clk); #1;
    rst = 1'b0; bus.re = 1'b0;
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid_dout", bus.dout, 32'h0000_0000);
    repeat (LAT + 2) begin @(posedge clk); #1; end
    chk("rst_mid_idle", {31'd0, bus.busy}, 32'd0);
    rd(32'h40, 2'd2, 32'h0102_0304, 1'b0);

    // Address aliasing above the storage depth
    wr(32'h1000, 2'd2, 32'h0BAD_F00D, 1'b0);
    rd(32'h0, 2'd2, 32'h0BAD_F00D, 1'b0);

    // dout holds after the read completes
    wait_idle();
    repeat (5) begin @(posedge clk); #1; end
    chk("dout_hold", bus.dout, 32'h0BAD_F00D);

    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
